// File: rtl/riscv_bu_rsb_pkg.sv
// Shared types and decode helpers for the EX-stage branch unit.
// Covers opcode constants, the resolved-operation enum and link-register detection.
package riscv_bu_rsb_pkg;

    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    localparam logic [2:0] F3_BEQ    = 3'b000;
    localparam logic [2:0] F3_BNE    = 3'b001;
    localparam logic [2:0] F3_BLT    = 3'b100;
    localparam logic [2:0] F3_BGE    = 3'b101;
    localparam logic [2:0] F3_BLTU   = 3'b110;
    localparam logic [2:0] F3_BGEU   = 3'b111;
    localparam logic [2:0] F3_FENCEI = 3'b001;

    typedef struct packed {
        logic        bubble;
        logic [31:0] instr;
    } instruction_t;

    typedef enum logic [3:0] {
        BU_NONE,
        BU_JAL,
        BU_JALR,
        BU_BEQ,
        BU_BNE,
        BU_BLT,
        BU_BGE,
        BU_BLTU,
        BU_BGEU,
        BU_FENCEI
    } bu_op_t;

    // x1 (ra) and x5 (t0) are the calling-convention link registers
    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    function automatic bu_op_t decode_op(input logic [31:0] insn);
        bu_op_t op;
        op = BU_NONE;
        case (insn[6:0])
            OPC_JAL:      op = BU_JAL;
            OPC_JALR:     if (insn[14:12] == 3'b000) op = BU_JALR;
            OPC_BRANCH: begin
                case (insn[14:12])
                    F3_BEQ:  op = BU_BEQ;
                    F3_BNE:  op = BU_BNE;
                    F3_BLT:  op = BU_BLT;
                    F3_BGE:  op = BU_BGE;
                    F3_BLTU: op = BU_BLTU;
                    F3_BGEU: op = BU_BGEU;
                    default: op = BU_NONE;
                endcase
            end
            OPC_MISC_MEM: if (insn[14:12] == F3_FENCEI) op = BU_FENCEI;
            default:      op = BU_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/riscv_rsb.sv
// Return-stack buffer: circular storage, pushing when full overwrites the oldest entry.
// Simultaneous push and pop replaces the top entry (pop-then-push).
module riscv_rsb #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] top_o,
    output logic            valid_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_inc;
    logic [CW-1:0]   cnt;

    assign ptr_inc = ptr + 1'b1;
    assign valid_o = (cnt != '0);
    assign top_o   = valid_o ? mem[ptr] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            ptr <= '0;
            cnt <= '0;
        end else if (push_i && pop_i && (cnt != '0)) begin
            mem[ptr] <= data_i;
        end else if (push_i) begin
            mem[ptr_inc] <= data_i;
            ptr          <= ptr_inc;
            if (cnt != CW'(DEPTH)) cnt <= cnt + 1'b1;
        end else if (pop_i && (cnt != '0)) begin
            ptr <= ptr - 1'b1;
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/riscv_bu_rsb.sv
// EX-stage branch unit: resolves JAL/JALR/Bxx/FENCE.I one cycle after issue,
// with return-stack prediction check, global history and perf counters.
module riscv_bu_rsb
    import riscv_bu_rsb_pkg::*;
#(
    parameter int               XLEN           = 32,
    parameter logic [XLEN-1:0]  PC_INIT        = 'h200,
    parameter int               BP_GLOBAL_BITS = 2,
    parameter int               RSB_DEPTH      = 4,
    parameter int               HAS_RVC        = 0,
    parameter int               CNT_BITS       = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      ex_stall_i,
    input  logic                      st_flush_i,
    input  logic [XLEN-1:0]           id_pc_i,
    input  instruction_t              id_insn_i,
    input  logic [1:0]                id_bp_predict_i,
    input  logic [XLEN-1:0]           opA_i,
    input  logic [XLEN-1:0]           opB_i,
    output logic [XLEN-1:0]           bu_nxt_pc_o,
    output logic                      bu_flush_o,
    output logic                      bu_misaligned_o,
    output logic                      cm_ic_invalidate_o,
    output logic                      cm_dc_clean_o,
    output logic                      bu_bp_btaken_o,
    output logic                      bu_bp_update_o,
    output logic [BP_GLOBAL_BITS-1:0] bu_bp_history_o,
    output logic [XLEN-1:0]           bu_rsb_top_o,
    output logic                      bu_rsb_valid_o,
    output logic [CNT_BITS-1:0]       bu_branch_cnt_o,
    output logic [CNT_BITS-1:0]       bu_mispredict_cnt_o
);

    bu_op_t                    op;
    logic [31:0]               instr;
    logic [4:0]                rd, rs1;
    logic                      valid, resolve, rd_link, rs1_link, is_fencei;
    logic [XLEN-1:0]           seq_pc, imm_uj, imm_sb, jalr_tgt, tgt;
    logic                      br_eq, br_lt, br_ltu, cond;
    logic                      redirect, taken, is_br, flush_pred, misaligned, push, pop;
    logic [XLEN-1:0]           rsb_top;
    logic                      rsb_valid;
    logic [BP_GLOBAL_BITS-1:0] history;
    logic                      unused_predict;

    assign instr          = id_insn_i.instr;
    assign op             = decode_op(instr);
    assign rd             = instr[11:7];
    assign rs1            = instr[19:15];
    assign rd_link        = is_link(rd);
    assign rs1_link       = is_link(rs1);
    assign is_fencei      = (op == BU_FENCEI);
    assign valid          = ~id_insn_i.bubble & ~st_flush_i & ~ex_stall_i;
    assign resolve        = valid && (op != BU_NONE);
    assign unused_predict = id_bp_predict_i[0];

    assign seq_pc   = id_pc_i + (((HAS_RVC != 0) && (instr[1:0] != 2'b11)) ? XLEN'(2) : XLEN'(4));
    assign imm_uj   = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_sb   = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign jalr_tgt = (opA_i + opB_i) & {{(XLEN-1){1'b1}}, 1'b0};

    assign br_eq  = (opA_i == opB_i);
    assign br_lt  = ($signed(opA_i) < $signed(opB_i));
    assign br_ltu = (opA_i < opB_i);

    always_comb begin
        cond = 1'b0;
        case (op)
            BU_BEQ:  cond = br_eq;
            BU_BNE:  cond = ~br_eq;
            BU_BLT:  cond = br_lt;
            BU_BGE:  cond = ~br_lt;
            BU_BLTU: cond = br_ltu;
            BU_BGEU: cond = ~br_ltu;
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        tgt        = seq_pc;
        redirect   = 1'b0;
        taken      = 1'b0;
        is_br      = 1'b0;
        flush_pred = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        case (op)
            BU_JAL: begin
                tgt        = id_pc_i + imm_uj;
                redirect   = 1'b1;
                taken      = 1'b1;
                flush_pred = ~id_bp_predict_i[1];
                push       = rd_link;
            end
            BU_JALR: begin
                tgt        = jalr_tgt;
                redirect   = 1'b1;
                taken      = 1'b1;
                flush_pred = 1'b1;
                if (rd_link) begin
                    push = 1'b1;
                    pop  = rs1_link && (rd != rs1);
                end else if (rs1_link) begin
                    // pure return: IF already predicted the RSB top
                    pop        = 1'b1;
                    flush_pred = ~(rsb_valid && (rsb_top[XLEN-1:1] == jalr_tgt[XLEN-1:1]));
                end
            end
            BU_BEQ, BU_BNE, BU_BLT, BU_BGE, BU_BLTU, BU_BGEU: begin
                is_br      = 1'b1;
                taken      = cond;
                redirect   = cond;
                flush_pred = cond ^ id_bp_predict_i[1];
                if (cond) tgt = id_pc_i + imm_sb;
            end
            default: ;
        endcase
        misaligned = redirect && ((HAS_RVC != 0) ? tgt[0] : (tgt[1:0] != 2'b00));
    end

    riscv_rsb #(
        .XLEN  (XLEN),
        .DEPTH (RSB_DEPTH)
    ) u_rsb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (resolve && push && !misaligned),
        .pop_i   (resolve && pop && !misaligned),
        .data_i  (seq_pc),
        .top_o   (rsb_top),
        .valid_o (rsb_valid)
    );

    assign bu_rsb_top_o   = rsb_top;
    assign bu_rsb_valid_o = rsb_valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bu_nxt_pc_o         <= PC_INIT;
            bu_flush_o          <= 1'b1;
            bu_misaligned_o     <= 1'b0;
            cm_ic_invalidate_o  <= 1'b0;
            cm_dc_clean_o       <= 1'b0;
            bu_bp_btaken_o      <= 1'b0;
            bu_bp_update_o      <= 1'b0;
            bu_bp_history_o     <= '0;
            history             <= '0;
            bu_branch_cnt_o     <= '0;
            bu_mispredict_cnt_o <= '0;
        end else if (!ex_stall_i) begin
            if (resolve) begin
                bu_nxt_pc_o        <= tgt;
                bu_flush_o         <= flush_pred | misaligned | is_fencei;
                bu_misaligned_o    <= misaligned;
                cm_ic_invalidate_o <= is_fencei;
                cm_dc_clean_o      <= is_fencei;
                bu_bp_btaken_o     <= taken;
                bu_bp_update_o     <= is_br & ~misaligned;
                bu_bp_history_o    <= history;
                if (is_br && !misaligned) history <= BP_GLOBAL_BITS'({history, taken});
                if (is_br) bu_branch_cnt_o <= bu_branch_cnt_o + CNT_BITS'(1);
                if (flush_pred && !misaligned) bu_mispredict_cnt_o <= bu_mispredict_cnt_o + CNT_BITS'(1);
            end else begin
                bu_flush_o         <= 1'b0;
                bu_misaligned_o    <= 1'b0;
                cm_ic_invalidate_o <= 1'b0;
                cm_dc_clean_o      <= 1'b0;
                bu_bp_btaken_o     <= 1'b0;
                bu_bp_update_o     <= 1'b0;
                bu_bp_history_o    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_riscv_bu_rsb.sv
// Self-checking bench for riscv_bu_rsb: directed scenarios plus random traffic
// compared against a queue-based behavioural model.
module tb_riscv_bu_rsb;
    import riscv_bu_rsb_pkg::*;

    localparam int K_NONE = 0, K_JAL = 1, K_JALR = 2, K_BR = 3, K_FENCEI = 4;
    localparam int DEPTH = 4;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         ex_stall_i, st_flush_i;
    logic [31:0]  id_pc_i, opA_i, opB_i;
    instruction_t id_insn_i;
    logic [1:0]   id_bp_predict_i;
    logic [31:0]  bu_nxt_pc_o, bu_rsb_top_o, bu_branch_cnt_o, bu_mispredict_cnt_o;
    logic         bu_flush_o, bu_misaligned_o, cm_ic_invalidate_o, cm_dc_clean_o;
    logic         bu_bp_btaken_o, bu_bp_update_o, bu_rsb_valid_o;
    logic [1:0]   bu_bp_history_o;

    always #5 clk_i = ~clk_i;

    riscv_bu_rsb #(
        .XLEN(32), .PC_INIT(32'h200), .BP_GLOBAL_BITS(2),
        .RSB_DEPTH(DEPTH), .HAS_RVC(0), .CNT_BITS(32)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .ex_stall_i(ex_stall_i), .st_flush_i(st_flush_i),
        .id_pc_i(id_pc_i), .id_insn_i(id_insn_i), .id_bp_predict_i(id_bp_predict_i),
        .opA_i(opA_i), .opB_i(opB_i), .bu_nxt_pc_o(bu_nxt_pc_o), .bu_flush_o(bu_flush_o),
        .bu_misaligned_o(bu_misaligned_o), .cm_ic_invalidate_o(cm_ic_invalidate_o),
        .cm_dc_clean_o(cm_dc_clean_o), .bu_bp_btaken_o(bu_bp_btaken_o),
        .bu_bp_update_o(bu_bp_update_o), .bu_bp_history_o(bu_bp_history_o),
        .bu_rsb_top_o(bu_rsb_top_o), .bu_rsb_valid_o(bu_rsb_valid_o),
        .bu_branch_cnt_o(bu_branch_cnt_o), .bu_mispredict_cnt_o(bu_mispredict_cnt_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] e_nxt, m_bcnt, m_mcnt;
    logic        e_flush, e_mis, e_ic, e_dc, e_bt, e_upd;
    logic [1:0]  e_hist, m_hist;
    logic [31:0] rsb_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        e_nxt = 32'h200; e_flush = 1'b1; e_mis = 0; e_ic = 0; e_dc = 0; e_bt = 0; e_upd = 0;
        e_hist = 0; m_hist = 0; m_bcnt = 0; m_mcnt = 0;
        rsb_q.delete();
    endtask

    task automatic check_all();
        logic [31:0] top;
        top = (rsb_q.size() != 0) ? rsb_q[$] : 32'h0;
        check_eq("nxt_pc",    bu_nxt_pc_o, e_nxt);
        check_eq("flush",     {31'b0, bu_flush_o}, {31'b0, e_flush});
        check_eq("misalign",  {31'b0, bu_misaligned_o}, {31'b0, e_mis});
        check_eq("ic_inv",    {31'b0, cm_ic_invalidate_o}, {31'b0, e_ic});
        check_eq("dc_clean",  {31'b0, cm_dc_clean_o}, {31'b0, e_dc});
        check_eq("btaken",    {31'b0, bu_bp_btaken_o}, {31'b0, e_bt});
        check_eq("bp_update", {31'b0, bu_bp_update_o}, {31'b0, e_upd});
        check_eq("history",   {30'b0, bu_bp_history_o}, {30'b0, e_hist});
        check_eq("rsb_valid", {31'b0, bu_rsb_valid_o}, {31'b0, rsb_q.size() != 0});
        check_eq("rsb_top",   bu_rsb_top_o, top);
        check_eq("br_cnt",    bu_branch_cnt_o, m_bcnt);
        check_eq("mp_cnt",    bu_mispredict_cnt_o, m_mcnt);
    endtask

    task automatic model_step(input int kind, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [2:0] f3, input logic [31:0] imm, input logic [31:0] pc,
                              input logic [31:0] a, input logic [31:0] b, input logic [1:0] pred,
                              input logic bubble, input logic sfl, input logic stall);
        logic [31:0] seq, tgt, top;
        logic redirect, taken, fp, br, mis, fence, do_push, do_pop, lk, rt;
        if (stall) return;
        if (bubble || sfl || kind == K_NONE) begin
            e_flush = 0; e_mis = 0; e_ic = 0; e_dc = 0; e_bt = 0; e_upd = 0; e_hist = 0;
            return;
        end
        seq = pc + 4; tgt = seq; redirect = 0; taken = 0; fp = 0; br = 0; fence = 0;
        do_push = 0; do_pop = 0;
        lk = (rd == 1) || (rd == 5);
        rt = (rs1 == 1) || (rs1 == 5);
        top = (rsb_q.size() != 0) ? rsb_q[$] : 32'h0;
        case (kind)
            K_JAL: begin
                tgt = pc + imm; redirect = 1; taken = 1; fp = !pred[1]; do_push = lk;
            end
            K_JALR: begin
                tgt = (a + b) & ~32'h1; redirect = 1; taken = 1;
                if (rt && !lk) begin
                    do_pop = 1;
                    fp = !((rsb_q.size() != 0) && ((top >> 1) == (tgt >> 1)));
                end else begin
                    fp = 1; do_push = lk; do_pop = lk && rt && (rd != rs1);
                end
            end
            K_BR: begin
                br = 1;
                case (f3)
                    3'b000:  taken = (a == b);
                    3'b001:  taken = (a != b);
                    3'b100:  taken = ($signed(a) < $signed(b));
                    3'b101:  taken = ($signed(a) >= $signed(b));
                    3'b110:  taken = (a < b);
                    default: taken = (a >= b);
                endcase
                redirect = taken;
                if (taken) tgt = pc + imm;
                fp = taken ^ pred[1];
            end
            default: fence = 1;
        endcase
        mis = redirect && ((tgt % 4) != 0);
        e_nxt = tgt; e_mis = mis; e_ic = fence; e_dc = fence; e_bt = taken;
        e_upd = br && !mis; e_hist = m_hist;
        e_flush = mis || fence || fp;
        if (br) m_bcnt = m_bcnt + 1;
        if (fp && !mis) m_mcnt = m_mcnt + 1;
        if (br && !mis) m_hist = {m_hist[0], taken};
        if (!mis) begin
            if (do_pop && rsb_q.size() != 0) void'(rsb_q.pop_back());
            if (do_push) begin
                if (rsb_q.size() == DEPTH) void'(rsb_q.pop_front());
                rsb_q.push_back(seq);
            end
        end
    endtask

    task automatic run_op(input int kind, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [2:0] f3, input logic [31:0] imm, input logic [31:0] pc,
                          input logic [31:0] a, input logic [31:0] b, input logic [1:0] pred,
                          input logic bubble, input logic sfl, input logic stall);
        logic [31:0] ins;
        case (kind)
            K_JAL:   ins = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            K_JALR:  ins = {b[11:0], rs1, 3'b000, rd, 7'b1100111};
            K_BR:    ins = {imm[12], imm[10:5], 5'd3, rs1, f3, imm[4:1], imm[11], 7'b1100011};
            K_FENCEI: ins = {17'b0, 3'b001, 5'b0, 7'b0001111};
            default: ins = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
        endcase
        id_insn_i.bubble = bubble;
        id_insn_i.instr  = ins;
        id_pc_i = pc; opA_i = a; opB_i = b; id_bp_predict_i = pred;
        st_flush_i = sfl; ex_stall_i = stall;
        model_step(kind, rd, rs1, f3, imm, pc, a, b, pred, bubble, sfl, stall);
        @(posedge clk_i);
        @(negedge clk_i);
        check_all();
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd1;
            2:       return 5'd5;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        logic [31:0] pc, a, b, imm;
        logic [2:0]  f3;
        int          kind, r;
        logic [4:0]  rd, rs1;

        id_insn_i = '0; id_insn_i.bubble = 1'b1;
        id_pc_i = 0; opA_i = 0; opB_i = 0; id_bp_predict_i = 0;
        st_flush_i = 0; ex_stall_i = 0;
        model_reset();
        repeat (2) @(negedge clk_i);
        check_all();
        check_eq("rst_nxt_pc", bu_nxt_pc_o, 32'h200);
        rst_ni = 1'b1;

        run_op(K_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        check_eq("bubble_flush", {31'b0, bu_flush_o}, 32'h0);

        run_op(K_BR, 0, 0, 3'b000, 32'h20, 32'h100, 5, 5, 2'b00, 0, 0, 0);
        check_eq("beq_nxt", bu_nxt_pc_o, 32'h120);
        check_eq("beq_mpcnt", bu_mispredict_cnt_o, 32'h1);

        run_op(K_JAL, 5'd1, 0, 0, 32'h100, 32'h400, 0, 0, 2'b10, 0, 0, 0);
        run_op(K_JALR, 5'd0, 5'd1, 0, 0, 32'h500, 32'h404, 0, 2'b00, 0, 0, 0);
        check_eq("ret_flush", {31'b0, bu_flush_o}, 32'h0);
        check_eq("ret_rsb_empty", {31'b0, bu_rsb_valid_o}, 32'h0);

        for (int k = 0; k < 5; k++)
            run_op(K_JAL, 5'd1, 0, 0, 32'h100, 32'h0C + 32'h10 * k, 0, 0, 2'b10, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            run_op(K_JALR, 5'd0, 5'd1, 0, 0, 32'h600, 32'h50 - 32'h10 * k, 0, 2'b00, 0, 0, 0);
            check_eq("rsb_pop_flush", {31'b0, bu_flush_o}, {31'b0, k == 4});
        end

        run_op(K_JALR, 5'd0, 5'd2, 0, 0, 32'h700, 32'h1001, 32'h2, 2'b00, 0, 0, 0);
        check_eq("jalr_mis_nxt", bu_nxt_pc_o, 32'h1002);
        check_eq("jalr_mis", {31'b0, bu_misaligned_o}, 32'h1);

        run_op(K_FENCEI, 0, 0, 0, 0, 32'h500, 0, 0, 2'b00, 0, 0, 0);
        check_eq("fencei_nxt", bu_nxt_pc_o, 32'h504);

        run_op(K_BR, 0, 0, 3'b001, 32'h40, 32'h300, 1, 2, 2'b00, 0, 0, 0);
        for (int k = 0; k < 3; k++)
            run_op(K_BR, 0, 0, 3'b001, 32'h80, 32'h380, 1, 2, 2'b00, 0, 0, 1);
        check_eq("stall_nxt", bu_nxt_pc_o, 32'h340);

        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                rst_ni = 1'b0;
                #1;
                model_reset();
                check_all();
                @(negedge clk_i);
                rst_ni = 1'b1;
            end
            r = $urandom_range(0, 9);
            kind = (r < 2) ? K_JAL : (r < 5) ? K_JALR : (r < 8) ? K_BR : (r < 9) ? K_FENCEI : K_NONE;
            rd = pick_reg(); rs1 = pick_reg();
            pc = $urandom & ~32'h3;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            f3 = 3'($urandom_range(0, 5));
            f3 = (f3 < 2) ? f3 : f3 + 3'd2;
            if (kind == K_JAL) imm = 32'(int'($urandom_range(0, 1048575)) - 524288);
            else               imm = 32'(int'($urandom_range(0, 8191)) - 4096);
            imm = imm & ~32'h1;
            if ($urandom_range(0, 3) != 0) imm = imm & ~32'h3;
            if (kind == K_JALR) begin
                b = 32'($urandom_range(0, 15) * 4);
                if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
                if (rsb_q.size() != 0 && $urandom_range(0, 1) == 1) begin
                    a = rsb_q[$];
                    b = 0;
                end
            end
            run_op(kind, rd, rs1, f3, imm, pc, a, b, 2'($urandom_range(0, 3)),
                   $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
